// File: rtl/day05_interval_engine.sv
// day05_interval_engine: streaming interval engine for the day-5 puzzle.
// Ranges "L-R\n" are insertion-sorted as they arrive, merged in place after the
// blank separator line, then every ID line is binary-searched in the merged list.
module day05_interval_engine #(
   parameter int VAL_W      = 64,
   parameter int MAX_RANGES = 256,
   parameter int IDX_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic [VAL_W-1:0] part1_result,
   output logic [VAL_W-1:0] part2_result,
   output logic             done,
   output logic             error
);
   localparam int CNT_W = IDX_W + 1;
   localparam int AW    = (MAX_RANGES > 1) ? $clog2(MAX_RANGES) : 1;

   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_PARSE_RANGE = 3'd1;
   localparam logic [2:0] ST_INSERT      = 3'd2;
   localparam logic [2:0] ST_MERGE       = 3'd3;
   localparam logic [2:0] ST_PARSE_ID    = 3'd4;
   localparam logic [2:0] ST_SEARCH      = 3'd5;
   localparam logic [2:0] ST_DONE        = 3'd6;
   localparam logic [2:0] ST_ERROR       = 3'd7;

   logic [2:0]       state;
   logic [VAL_W-1:0] num, l_val, ins_l, ins_r, cur_start, cur_end, key;
   logic             line_digit, last_seen;
   logic [CNT_W-1:0] count, m_cnt, ptr, low, high;
   logic [VAL_W-1:0] arr_l [MAX_RANGES];
   logic [VAL_W-1:0] arr_r [MAX_RANGES];

   logic             accept, is_digit, is_nl, range_ok, extend, merge_emit, full;
   logic [VAL_W-1:0] num_next, seg_len, probe_l, probe_r, next_l, next_r;
   logic [CNT_W:0]   mid_sum;
   logic [CNT_W-1:0] mid, ins_pos;
   logic [MAX_RANGES-1:0] gt;

   assign s_ready  = (state == ST_PARSE_RANGE) || (state == ST_PARSE_ID);
   assign accept   = s_valid && s_ready;
   assign is_digit = (s_data >= 8'h30) && (s_data <= 8'h39);
   assign is_nl    = (s_data == 8'h0A);
   assign num_next = is_digit ? ((num << 3) + (num << 1) + {{(VAL_W-4){1'b0}}, s_data[3:0]}) : num;
   assign range_ok = is_nl && line_digit && (num >= l_val);
   assign full     = (count == CNT_W'(MAX_RANGES));
   assign next_l   = arr_l[ptr[AW-1:0]];
   assign next_r   = arr_r[ptr[AW-1:0]];
   // adjacency test done one bit wider so an all-ones end never wraps
   assign extend   = ({1'b0, next_l} <= ({1'b0, cur_end} + {{VAL_W{1'b0}}, 1'b1}));
   assign seg_len  = cur_end - cur_start + {{(VAL_W-1){1'b0}}, 1'b1};
   assign merge_emit = (state == ST_MERGE) && (count != {CNT_W{1'b0}}) && (ptr != {CNT_W{1'b0}})
                       && ((ptr >= count) || !extend);
   assign mid_sum  = {1'b0, low} + {1'b0, high};
   assign mid      = CNT_W'(mid_sum >> 1);
   assign probe_l  = arr_l[mid[AW-1:0]];
   assign probe_r  = arr_r[mid[AW-1:0]];

   // flag entries that must shift up and find the first of them (insert slot)
   always_comb begin
      gt      = '0;
      ins_pos = count;
      for (int i = MAX_RANGES - 1; i >= 0; i--) begin
         if ((CNT_W'(i) < count) && (arr_l[i] > ins_l)) begin
            gt[i]   = 1'b1;
            ins_pos = CNT_W'(i);
         end else begin
            gt[i] = 1'b0;
         end
      end
   end

   // range storage: sorted insert with parallel shift, merged list compacted in place
   always_ff @(posedge clk) begin
      if ((state == ST_INSERT) && !full) begin
         for (int i = 0; i < MAX_RANGES - 1; i++) begin
            if (gt[i]) begin
               arr_l[i+1] <= arr_l[i];
               arr_r[i+1] <= arr_r[i];
            end
         end
         arr_l[ins_pos[AW-1:0]] <= ins_l;
         arr_r[ins_pos[AW-1:0]] <= ins_r;
      end else if (merge_emit) begin
         arr_l[m_cnt[AW-1:0]] <= cur_start;
         arr_r[m_cnt[AW-1:0]] <= cur_end;
      end
   end

   // control FSM: parsing, insert bookkeeping, merge sweep, binary search, results
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         num          <= '0;
         l_val        <= '0;
         ins_l        <= '0;
         ins_r        <= '0;
         cur_start    <= '0;
         cur_end      <= '0;
         key          <= '0;
         line_digit   <= 1'b0;
         last_seen    <= 1'b0;
         count        <= '0;
         m_cnt        <= '0;
         ptr          <= '0;
         low          <= '0;
         high         <= '0;
         part1_result <= '0;
         part2_result <= '0;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: state <= ST_PARSE_RANGE;
            ST_PARSE_RANGE: begin
               if (accept) begin
                  if (s_last) last_seen <= 1'b1;
                  if (is_digit) begin
                     num        <= num_next;
                     line_digit <= 1'b1;
                  end else if (s_data == 8'h2D) begin
                     l_val <= num;
                     num   <= '0;
                  end else if (is_nl) begin
                     num        <= '0;
                     l_val      <= '0;
                     line_digit <= 1'b0;
                     // an inverted range is dropped but parsing carries on
                     if (line_digit && (num < l_val)) error <= 1'b1;
                  end
                  if (range_ok) begin
                     ins_l <= l_val;
                     ins_r <= num;
                     state <= ST_INSERT;
                  end else if (s_last || (is_nl && !line_digit)) begin
                     ptr   <= '0;
                     state <= ST_MERGE;
                  end
               end
            end
            ST_INSERT: begin
               if (full) begin
                  error <= 1'b1;
                  done  <= 1'b1;
                  state <= ST_ERROR;
               end else begin
                  count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
                  ptr   <= '0;
                  state <= last_seen ? ST_MERGE : ST_PARSE_RANGE;
               end
            end
            ST_MERGE: begin
               if ((count == {CNT_W{1'b0}}) || (ptr >= count)) begin
                  if (count == {CNT_W{1'b0}}) begin
                     part2_result <= '0;
                     m_cnt        <= '0;
                  end else begin
                     part2_result <= part2_result + seg_len;
                     m_cnt        <= m_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                  end
                  done  <= last_seen;
                  state <= last_seen ? ST_DONE : ST_PARSE_ID;
               end else if (ptr == {CNT_W{1'b0}}) begin
                  cur_start    <= next_l;
                  cur_end      <= next_r;
                  part2_result <= '0;
                  m_cnt        <= '0;
                  ptr          <= ptr + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  if (extend) begin
                     if (next_r > cur_end) cur_end <= next_r;
                  end else begin
                     part2_result <= part2_result + seg_len;
                     m_cnt        <= m_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                     cur_start    <= next_l;
                     cur_end      <= next_r;
                  end
                  ptr <= ptr + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_PARSE_ID: begin
               if (accept) begin
                  if (is_digit) begin
                     num        <= num_next;
                     line_digit <= 1'b1;
                  end
                  if (s_last) begin
                     last_seen <= 1'b1;
                     if (line_digit || is_digit) begin
                        key        <= num_next;
                        low        <= '0;
                        high       <= m_cnt;
                        num        <= '0;
                        line_digit <= 1'b0;
                        state      <= ST_SEARCH;
                     end else begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                     end
                  end else if (is_nl && line_digit) begin
                     key        <= num;
                     low        <= '0;
                     high       <= m_cnt;
                     num        <= '0;
                     line_digit <= 1'b0;
                     state      <= ST_SEARCH;
                  end
               end
            end
            ST_SEARCH: begin
               // window is [low, high); a probe that empties it ends the search
               if (low >= high) begin
                  done  <= last_seen;
                  state <= last_seen ? ST_DONE : ST_PARSE_ID;
               end else if (key < probe_l) begin
                  high <= mid;
                  if (mid == low) begin
                     done  <= last_seen;
                     state <= last_seen ? ST_DONE : ST_PARSE_ID;
                  end
               end else if (key > probe_r) begin
                  low <= mid + {{(CNT_W-1){1'b0}}, 1'b1};
                  if ((mid + {{(CNT_W-1){1'b0}}, 1'b1}) == high) begin
                     done  <= last_seen;
                     state <= last_seen ? ST_DONE : ST_PARSE_ID;
                  end
               end else begin
                  part1_result <= part1_result + {{(VAL_W-1){1'b0}}, 1'b1};
                  done         <= last_seen;
                  state        <= last_seen ? ST_DONE : ST_PARSE_ID;
               end
            end
            ST_DONE:  done <= 1'b1;
            ST_ERROR: begin
               done  <= 1'b1;
               error <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
